// File: rtl/instr_mem_prog.sv
// instr_mem_prog: byte-addressed instruction memory with a registered
// little-endian word fetch port and a valid/ready byte-stream loader.
// Ports:
//   clk, rst (async, active low)
//   fetch:  rd_en, rd_addr -> dout, dout_valid, misaligned (1-cycle latency)
//   loader: ld_start, ld_valid, ld_byte, ld_last -> ld_ready, ld_done, busy
// Build option: define INSTR_MEM_INIT_EN to preload the array from INIT_IMAGE.
module instr_mem_prog #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter     INIT_FILE  = "program.hex",
   parameter logic [8*(2**ADDR_WIDTH)-1:0] INIT_IMAGE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  misaligned,
   input  logic                  ld_start,
   input  logic                  ld_valid,
   input  logic [7:0]            ld_byte,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  ld_done,
   output logic                  busy
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [7:0]            mem [0:DEPTH-1];
   logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  fetch;
   logic                  misalign_c;
   logic                  wr_en;

`ifdef INSTR_MEM_INIT_EN
   initial begin
      for (int i = 0; i < DEPTH; i++)
         mem[i] = INIT_IMAGE[8*i +: 8];
   end
`else
   // The image only matters when preloading is enabled.
   if (INIT_FILE == "") begin : g_no_image
   end
`endif

   // Each fetched byte lane indexes the array independently, so a word
   // that runs past the top of the array wraps back to byte 0.
   for (genvar g = 0; g < NBYTES; g++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      assign a = rd_addr + ADDR_WIDTH'(g);
      assign rd_word[8*g +: 8] = mem[a];
   end

   // A load request wins over a fetch issued in the same cycle.
   assign fetch      = (state == IDLE) && rd_en && !ld_start;
   assign misalign_c = (32'(rd_addr) % NBYTES) != 32'd0;
   assign wr_en      = (state == LOAD) && ld_valid;

   assign ld_ready = (state == LOAD);
   assign ld_done  = (state == DONE);
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      unique case (state)
         IDLE: begin
            if (ld_start) begin
               state_nxt = LOAD;
               ptr_nxt   = '0;
            end
         end
         LOAD: begin
            if (ld_valid) begin
               ptr_nxt = ptr + 1'b1;
               if (ld_last || ptr == LAST_PTR)
                  state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Array is deliberately not reset; a reset never disturbs its contents.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[ptr] <= ld_byte;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         dout_valid <= fetch;
         misaligned <= fetch && misalign_c;
         if (fetch)
            dout <= rd_word;
      end
   end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed bench for instr_mem_prog: loader handshake, fetch, wrap,
// misalignment, fetch/load collision and asynchronous reset mid-load.
module tb_instr_mem_prog;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic [31:0] dout;
   logic        dout_valid;
   logic        misaligned;
   logic        ld_start = 1'b0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_byte = '0;
   logic        ld_last = 1'b0;
   logic        ld_ready;
   logic        ld_done;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int base;

   always #5 clk = ~clk;

   instr_mem_prog #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .INIT_FILE ("program.hex"),
      .INIT_IMAGE(2048'hDEADBEEF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .dout      (dout),
      .dout_valid(dout_valid),
      .misaligned(misaligned),
      .ld_start  (ld_start),
      .ld_valid  (ld_valid),
      .ld_byte   (ld_byte),
      .ld_last   (ld_last),
      .ld_ready  (ld_ready),
      .ld_done   (ld_done),
      .busy      (busy)
   );

   always @(negedge clk)
      if (ld_done === 1'b1)
         done_cnt++;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
   endtask

   task automatic send(logic [7:0] b, logic last);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
   endtask

   task automatic end_send();
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic fetch(logic [7:0] a);
      @(negedge clk);
      rd_en   = 1'b1;
      rd_addr = a;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_dout", dout, 32'h0);
      chk("rst_dv", {31'b0, dout_valid}, 32'h0);
      chk("rst_mis", {31'b0, misaligned}, 32'h0);
      chk("rst_rdy", {31'b0, ld_ready}, 32'h0);
      chk("rst_done", {31'b0, ld_done}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

`ifdef INSTR_MEM_INIT_EN
      fetch(8'h00);
      chk("init_w0", dout, 32'hDEADBEEF);
`endif

      // short program ending on ld_last
      base = done_cnt;
      start_load();
      chk("t1_rdy", {31'b0, ld_ready}, 32'h1);
      chk("t1_busy", {31'b0, busy}, 32'h1);
      send(8'h13, 1'b0);
      send(8'h05, 1'b0);
      send(8'h10, 1'b0);
      send(8'h00, 1'b1);
      end_send();
      chk("t1_done", {31'b0, ld_done}, 32'h1);
      chk("t1_rdy_d", {31'b0, ld_ready}, 32'h0);
      chk("t1_busy_d", {31'b0, busy}, 32'h1);
      @(negedge clk);
      chk("t1_done_off", {31'b0, ld_done}, 32'h0);
      chk("t1_idle", {31'b0, busy}, 32'h0);
      fetch(8'h00);
      chk("t1_dout", dout, 32'h00100513);
      chk("t1_dv", {31'b0, dout_valid}, 32'h1);
      chk("t1_mis", {31'b0, misaligned}, 32'h0);
      chk("t1_pulses", done_cnt - base, 32'd1);
      @(negedge clk);
      chk("t1_dv_off", {31'b0, dout_valid}, 32'h0);
      chk("t1_hold", dout, 32'h00100513);

      // stall with ld_valid low for 5 cycles
      start_load();
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      end_send();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t3_rdy%0d", i), {31'b0, ld_ready}, 32'h1);
         chk($sformatf("t3_busy%0d", i), {31'b0, busy}, 32'h1);
      end
      send(8'hCC, 1'b0);
      send(8'hDD, 1'b1);
      end_send();
      @(negedge clk);
      fetch(8'h00);
      chk("t3_dout", dout, 32'hDDCCBBAA);

      // fetch colliding with ld_start
      @(negedge clk);
      rd_en    = 1'b1;
      rd_addr  = 8'h04;
      ld_start = 1'b1;
      @(negedge clk);
      rd_en    = 1'b0;
      ld_start = 1'b0;
      chk("t4_dv", {31'b0, dout_valid}, 32'h0);
      chk("t4_hold", dout, 32'hDDCCBBAA);
      chk("t4_rdy", {31'b0, ld_ready}, 32'h1);

      // same session: full array, array[i]=i, stray ld_start at 100
      base = done_cnt;
      for (int i = 0; i < 256; i++) begin
         send(8'(i), 1'b0);
         ld_start = (i == 100);
      end
      end_send();
      ld_start = 1'b0;
      chk("t2_done", {31'b0, ld_done}, 32'h1);
      @(negedge clk);
      chk("t2_pulses", done_cnt - base, 32'd1);
      fetch(8'hFE);
      chk("t2_wrap", dout, 32'h0100FFFE);
      chk("t2_mis", {31'b0, misaligned}, 32'h1);
      fetch(8'hFD);
      chk("t2_wrap3", dout, 32'h00FFFEFD);
      fetch(8'h64);
      chk("t2_mid", dout, 32'h67666564);
      chk("t2_mid_mis", {31'b0, misaligned}, 32'h0);

      // loader strobes without ld_start are ignored in IDLE
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = 8'h55;
      ld_last  = 1'b1;
      @(negedge clk);
      chk("t6_busy", {31'b0, busy}, 32'h0);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      fetch(8'h00);
      chk("t6_dout", dout, 32'h03020100);

      // asynchronous reset after two of four bytes
      base = done_cnt;
      start_load();
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      end_send();
      #2;
      rst = 1'b0;
      #1;
      chk("t5_busy", {31'b0, busy}, 32'h0);
      chk("t5_rdy", {31'b0, ld_ready}, 32'h0);
      chk("t5_dout", dout, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      fetch(8'h00);
      chk("t5_keep", dout, 32'h03022211);
      chk("t5_dv", {31'b0, dout_valid}, 32'h1);
      chk("t5_pulses", done_cnt - base, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
